ldm_stm_sequencer: RTL and testbench
====================================

Name: ldm_stm_sequencer

Overview:
- Multi-register transfer engine for LDM/STM (and PUSH/POP, issued as LDM/STM) in the mock ARMv7-M core.
- Walks a 16-bit register list in ascending order, one register per beat:
  - STM: reads registers through a register-file read port and writes them to memory.
  - LDM: reads words from memory and writes them into the register file.
- Sits between decode/execute and the data-memory port. Drives the register file's read_addr/write_addr/write_data/write_en side, the opposite end of that interface.

Parameters:
- ADDR_W, 32, memory address width
- NUM_REGS, 16, register-list width; must equal register-file depth

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk
- start  in  1  one-cycle request; accepted only in IDLE
- is_load  in  1  1 = LDM (memory to registers), 0 = STM (registers to memory)
- reg_list  in  16  bit n set = transfer Rn
- base_addr  in  32  start address, increment-after addressing
- busy  out  1  high from the cycle after an accepted start through the DONE cycle
- done  out  1  one-cycle completion pulse
- end_addr  out  32  base_addr + 4*popcount(reg_list), used for writeback; valid while done=1
- rf_read_addr  out  4  register-file read port address
- rf_read_data  in  32  combinational read data for rf_read_addr
- rf_write_addr  out  4  register-file write address
- rf_write_data  out  32  register-file write data
- rf_write_en  out  1  register-file write strobe; register file commits on posedge
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = store
- mem_addr  out  32  word address; bits [1:0] are always 00
- mem_wdata  out  32  store data
- mem_ack  in  1  memory accepts the beat (stores) or returns mem_rdata (loads) in this cycle
- mem_rdata  in  32  load data, valid when mem_ack=1

Behaviour:
- States: IDLE, XFER, DONE.
- Reset:
  - rst_n=0 at a posedge forces IDLE, clears the pending mask, address register and end_addr.
  - While rst_n=0: busy, done, mem_req and rf_write_en are forced 0 combinationally; all address/data outputs are 0.
  - Reset in mid-transfer abandons the transfer. No further beats, and no register write in the reset cycle.
- IDLE:
  - busy=0, rf_read_addr=0.
  - On start=1: latch is_load, pending<=reg_list, addr<={base_addr[31:2],2'b00}, end_addr<=aligned base + 4*popcount(reg_list) mod 2^32.
  - Next state is XFER if reg_list!=0, else DONE.
- XFER:
  - cur = lowest set bit of pending.
  - mem_req=1, mem_addr=addr, mem_we=~is_load.
  - STM: rf_read_addr=cur, mem_wdata=rf_read_data in the same cycle.
  - All request outputs stay stable until mem_ack.
  - On mem_ack, LDM: rf_write_en=1, rf_write_addr=cur, rf_write_data=mem_rdata, all combinationally in the ack cycle.
  - On mem_ack, both directions: clear bit cur in pending, addr<=addr+4 (wraps mod 2^32).
  - If the cleared pending is zero, go to DONE; otherwise stay in XFER. The next beat starts the following cycle, so sustained ack gives 1 beat/cycle.
- DONE: done=1, busy=1, end_addr valid. Next state is IDLE.
- Latency: N set bits with zero-wait ack:
  - start sampled at edge 0
  - beats in cycles 1..N
  - done in cycle N+1
  - an empty list gives done in cycle 1
- start while not IDLE is ignored; there is no queueing.
- mem_ack while mem_req=0 is ignored.
- rf_write_en is never asserted for STM. The register file is never read-modified by this block.
- R15 in the list is transferred like any register. PC side effects are handled upstream.
- Memory address wrap-around past 0xFFFFFFFC continues at 0x00000000.

Decomposition:
- Shared core package (armv7m_pkg):
  - REG_ADDR_W=4, NUM_REGS=16, WORD_BYTES=4
  - typedef enum lsm_state_t {IDLE, XFER, DONE}
  - typedef logic [15:0] reg_list_t
- One sub-module: lsb_priority_enc. 16-bit mask in; 4-bit index of lowest set bit and valid flag out; purely combinational.
- The popcount for end_addr is an inline function in the package.

Test Plan:
- STM, reg_list=16'h00A5, base=0x1000, R0=1, R2=3, R5=6, R7=8, mem_ack tied 1 -> writes (0x1000,1), (0x1004,3), (0x1008,6), (0x100C,8) on cycles 1-4; done at cycle 5 with end_addr=0x1010.
- LDM, reg_list=16'h8001, base=0x2002, ack returns 0xAAAA0000 then 0xBBBB0000 -> R0=0xAAAA0000, R15=0xBBBB0000; mem_addr 0x2000 then 0x2004; end_addr=0x2008.
- STM, reg_list=16'h0003, ack delayed 3 cycles per beat -> mem_req, mem_addr and mem_wdata stay stable during the waits; done 9 cycles after start.
- reg_list=0 -> no mem_req, done pulse in cycle 1, end_addr=base; a second start during busy is ignored.
- LDM, reg_list=16'hFFFF, base=0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, ...; R0..R15 loaded; end_addr=0x00000038.
- LDM, reg_list=16'h00FF, rst_n=0 asserted during the 3rd beat -> only R0 and R1 updated; next cycle is IDLE with busy=0; no done pulse.

Source files
------------

// File: rtl/armv7m_pkg.sv
// Shared core definitions for the mock ARMv7-M core: register-file geometry,
// load/store-multiple sequencer states and a register-list popcount helper.
package armv7m_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int NUM_REGS   = 16;
    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } lsm_state_t;

    typedef logic [NUM_REGS-1:0] reg_list_t;

    // Number of registers named in a list; 5 bits cover the all-ones case.
    function automatic logic [4:0] popcount(input reg_list_t list);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt = cnt + 5'(list[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/lsb_priority_enc.sv
// Lowest-set-bit priority encoder: gives the index of the least significant
// set bit of a register mask, plus a flag telling whether any bit is set.
module lsb_priority_enc
    import armv7m_pkg::*;
(
    input  logic [NUM_REGS-1:0]   mask,
    output logic [REG_ADDR_W-1:0] index,
    output logic                  valid
);

    // Scan from the top down so the lowest set bit is the last one to win.
    always_comb begin
        // NOTE: every output gets a default before the loop; a path that left
        // one unassigned would make synthesis hold its old value in a latch.
        index = '0;
        valid = 1'b0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                index = REG_ADDR_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM multi-register transfer engine. Walks the register list from R0
// upward, moving one word per beat between the register file and the data
// memory port, with increment-after addressing and a one-cycle done pulse
// carrying the writeback address.
module ldm_stm_sequencer #(
    parameter int ADDR_W   = 32,
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_load,
    input  logic [15:0]       reg_list,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] end_addr,
    output logic [3:0]        rf_read_addr,
    input  logic [31:0]       rf_read_data,
    output logic [3:0]        rf_write_addr,
    output logic [31:0]       rf_write_data,
    output logic              rf_write_en,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    import armv7m_pkg::lsm_state_t;
    import armv7m_pkg::IDLE;
    import armv7m_pkg::XFER;
    import armv7m_pkg::DONE;
    import armv7m_pkg::WORD_BYTES;
    import armv7m_pkg::popcount;

    lsm_state_t          state;
    logic                is_load_q;
    logic [15:0]         pending;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   end_addr_q;

    logic [3:0]          cur;
    logic                cur_valid;
    logic [15:0]         pending_next;
    logic [ADDR_W-1:0]   aligned_base;
    logic                beat;
    logic                store_beat;
    logic                load_ack;

    lsb_priority_enc u_enc (
        .mask  (pending),
        .index (cur),
        .valid (cur_valid)
    );

    // Word-align the start address and pre-clear the bit being retired.
    always_comb begin
        aligned_base = base_addr & ~ADDR_W'(WORD_BYTES - 1);
        pending_next = pending & (pending - 16'd1);
    end

    // Control FSM plus pending mask, address and writeback registers.
    always_ff @(posedge clk) begin
        // NOTE: state lives in flops, so every assignment here is non-blocking;
        // blocking ones would let later lines see this cycle's new values.
        if (!rst_n) begin
            state      <= IDLE;
            is_load_q  <= 1'b0;
            pending    <= '0;
            addr_q     <= '0;
            end_addr_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        is_load_q  <= is_load;
                        pending    <= reg_list;
                        addr_q     <= aligned_base;
                        end_addr_q <= aligned_base
                                      + ADDR_W'({popcount(reg_list), 2'b00});
                        state      <= (reg_list != '0) ? XFER : DONE;
                    end
                end
                XFER: begin
                    if (mem_ack && cur_valid) begin
                        pending <= pending_next;
                        addr_q  <= addr_q + ADDR_W'(WORD_BYTES);
                        if (pending_next == '0) begin
                            state <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Port drive: everything is gated by rst_n so an abandoned beat is silent.
    always_comb begin
        beat       = rst_n && (state == XFER) && cur_valid;
        store_beat = beat && !is_load_q;
        load_ack   = beat && is_load_q && mem_ack;

        busy          = rst_n && (state != IDLE);
        done          = rst_n && (state == DONE);
        end_addr      = rst_n ? end_addr_q : '0;

        mem_req       = beat;
        mem_we        = store_beat;
        mem_addr      = beat ? addr_q : '0;
        rf_read_addr  = store_beat ? cur : 4'd0;
        mem_wdata     = store_beat ? rf_read_data : 32'd0;

        rf_write_en   = load_ack;
        rf_write_addr = load_ack ? cur : 4'd0;
        rf_write_data = load_ack ? mem_rdata : 32'd0;
    end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Self-checking bench for ldm_stm_sequencer. A list-of-beats reference model
// (register indices in ascending order, word addresses base+4k) drives a
// memory responder with random wait states and a simple register file.
module tb_ldm_stm_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_load;
    logic [15:0] reg_list;
    logic [31:0] base_addr;
    logic        busy;
    logic        done;
    logic [31:0] end_addr;
    logic [3:0]  rf_read_addr;
    logic [31:0] rf_read_data;
    logic [3:0]  rf_write_addr;
    logic [31:0] rf_write_data;
    logic        rf_write_en;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Register file seen by the DUT, and the model's expectation of it.
    logic [31:0] rf [16] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8,
                             32'd9, 32'd10, 32'd11, 32'd12, 32'd13, 32'd14, 32'd15, 32'd16};
    logic [31:0] exp_rf [16];

    always #5 clk = ~clk;

    assign rf_read_data = rf[rf_read_addr];

    always @(posedge clk) begin
        if (rf_write_en) rf[rf_write_addr] <= rf_write_data;
    end

    ldm_stm_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .is_load       (is_load),
        .reg_list      (reg_list),
        .base_addr     (base_addr),
        .busy          (busy),
        .done          (done),
        .end_addr      (end_addr),
        .rf_read_addr  (rf_read_addr),
        .rf_read_data  (rf_read_data),
        .rf_write_addr (rf_write_addr),
        .rf_write_data (rf_write_data),
        .rf_write_en   (rf_write_en),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic int pick_wait(input int mode);
        return (mode < 0) ? int'($urandom_range(0, 3)) : mode;
    endfunction

    // One LDM/STM transfer. wait_mode<0 gives random wait states per beat;
    // rst_beat>=0 asserts reset during that beat; poke_start re-requests in cycle 1.
    task automatic run_xfer(input bit load, input logic [15:0] list,
                            input logic [31:0] base, input int wait_mode,
                            input logic [31:0] data0, input int rst_beat,
                            input bit poke_start);
        int          regs[$];
        logic [31:0] a0;
        logic [31:0] exp_end;
        int          k;
        int          wleft;
        int          done_cyc;
        int          total_wait;
        bit          finished;
        bit          in_reset;

        a0 = base & 32'hFFFF_FFFC;
        for (int i = 0; i < 16; i++) if (list[i]) regs.push_back(i);
        exp_end    = a0 + 32'(4 * regs.size());
        k          = 0;
        done_cyc   = 0;
        total_wait = 0;
        finished   = 1'b0;
        in_reset   = 1'b0;
        wleft      = pick_wait(wait_mode);

        @(negedge clk);
        is_load   = load;
        reg_list  = list;
        base_addr = base;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;

        for (int cyc = 1; cyc <= 300 && !finished; cyc++) begin
            if (poke_start && cyc == 1) begin
                start    = 1'b1;
                reg_list = ~list;
                is_load  = ~load;
            end
            check("busy", busy, 1);
            check("done", done, k == regs.size());
            check("mem_req", mem_req, k < regs.size());
            if (k == regs.size()) begin
                check("end_addr", end_addr, exp_end);
                done_cyc = cyc;
                finished = 1'b1;
            end else begin
                check("mem_addr", mem_addr, a0 + 32'(4 * k));
                check("mem_we", mem_we, !load);
                if (!load) check("mem_wdata", mem_wdata, exp_rf[regs[k]]);
                if (rst_beat == k) begin
                    rst_n     = 1'b0;
                    mem_ack   = 1'b1;
                    mem_rdata = 32'hDEAD_BEEF;
                    #1;
                    check("rst_write_en", rf_write_en, 0);
                    check("rst_mem_req", mem_req, 0);
                    check("rst_busy", busy, 0);
                    check("rst_mem_addr", mem_addr, 0);
                    in_reset = 1'b1;
                    finished = 1'b1;
                end else if (wleft > 0) begin
                    wleft--;
                    total_wait++;
                    #1;
                    check("wait_write_en", rf_write_en, 0);
                end else begin
                    mem_ack   = 1'b1;
                    mem_rdata = data0 + 32'(k) * 32'h1111_0000;
                    #1;
                    if (load) begin
                        check("ld_write_en", rf_write_en, 1);
                        check("ld_write_addr", rf_write_addr, regs[k]);
                        check("ld_write_data", rf_write_data, mem_rdata);
                        exp_rf[regs[k]] = mem_rdata;
                    end else begin
                        check("st_write_en", rf_write_en, 0);
                    end
                    k++;
                    wleft = pick_wait(wait_mode);
                end
            end
            @(negedge clk);
            mem_ack = 1'b0;
            start   = 1'b0;
            if (in_reset) rst_n = 1'b1;
        end

        if (!finished) begin
            checks++;
            fails++;
            $error("FAIL done_timeout: observed no done expected done within 300 cycles");
        end

        if (finished && !in_reset) begin
            check("done_cycle", done_cyc, 1 + regs.size() + total_wait);
        end

        // Back in IDLE: nothing busy, and a stray ack must not write anything.
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_mem_req", mem_req, 0);
        mem_ack = 1'b1;
        #1;
        check("idle_ack_write_en", rf_write_en, 0);
        @(negedge clk);
        mem_ack = 1'b0;
        check("idle_after_ack_busy", busy, 0);

        for (int i = 0; i < 16; i++) begin
            check($sformatf("rf_r%0d", i), rf[i], exp_rf[i]);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        is_load   = 1'b0;
        reg_list  = '0;
        base_addr = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < 16; i++) exp_rf[i] = 32'(i + 1);

        // Reset: all strobes and address/data outputs held at zero.
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_mem_req", mem_req, 0);
        check("reset_write_en", rf_write_en, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_end_addr", end_addr, 0);
        check("reset_read_addr", rf_read_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_busy", busy, 0);
        check("post_reset_end_addr", end_addr, 0);

        // STM R0,R2,R5,R7 at 0x1000 with ack tied high.
        run_xfer(1'b0, 16'h00A5, 32'h0000_1000, 0, 32'h0, -1, 1'b0);
        // LDM R0,R15 from unaligned 0x2002.
        run_xfer(1'b1, 16'h8001, 32'h0000_2002, 0, 32'hAAAA_0000, -1, 1'b0);
        // STM R0,R1 with three wait states per beat.
        run_xfer(1'b0, 16'h0003, 32'h0000_3000, 3, 32'h0, -1, 1'b0);
        // Empty list, with a second start while busy.
        run_xfer(1'b1, 16'h0000, 32'h0000_4000, 0, 32'h0, -1, 1'b1);
        // Full LDM wrapping past the top of memory.
        run_xfer(1'b1, 16'hFFFF, 32'hFFFF_FFF8, 0, $urandom, -1, 1'b0);
        // LDM R0..R7 abandoned by reset during the third beat.
        run_xfer(1'b1, 16'h00FF, 32'h0000_5000, 0, $urandom, 2, 1'b0);

        // Randomized transfers with random wait states.
        for (int t = 0; t < 12; t++) begin
            run_xfer(1'($urandom_range(0, 1)), 16'($urandom), $urandom, -1,
                     $urandom, -1, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
